branch_resolve_unit: RTL and testbench

- Consumer of the signed/unsigned/equal comparator flags (LT, LTU, EQ) in the EX stage.
- Decides the actual branch or jump outcome from FUNCT3 and the instruction type, and checks it against the fetch-stage prediction.
- On a mispredict, issues a registered redirect to fetch using a valid/ready handshake, then asserts a pipeline flush for a fixed number of cycles.
- Keeps saturating branch and mispredict performance counters.

---
 rtl/common_params.sv | 24 ++
 rtl/branch_resolve_unit_sat_counter.sv | 27 ++
 rtl/branch_resolve_unit.sv | 170 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_params.sv
// Shared parameters and types for the EX-stage control-flow logic.
//   BITS          : datapath / PC width
//   INSTR_BYTES   : size of one instruction, used for the fall-through PC
//   F3_*          : FUNCT3 encodings of the conditional branches
//   brs_state_t   : state of the branch resolve unit redirect sequencer
package common_params;

    localparam int BITS        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } brs_state_t;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter used for the branch performance statistics.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once the count is all ones)
//   count : current value, sticks at 2^W-1
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution.
// Resolves the real outcome of a branch/JAL/JALR from the comparator flags,
// compares it with the fetch prediction, and on a mispredict sends a
// registered redirect to fetch (valid/ready) followed by a pipeline flush
// lasting FLUSH_CYCLES cycles counted from the handshake cycle.
//   clk, rst                   : clock, synchronous active-high reset
//   EX_VALID / EX_READY        : instruction handshake from EX
//   IS_BRANCH/IS_JAL/IS_JALR   : instruction type (JALR > JAL > BRANCH)
//   FUNCT3, LT, LTU, EQ        : branch condition and comparator flags
//   PRED_TAKEN, PC, TARGET     : prediction, instruction address, target
//   REDIR_VALID/READY, REDIR_PC: redirect channel to fetch
//   FLUSH                      : squash younger instructions
//   TAKEN, ILLEGAL             : last resolved outcome, bad-FUNCT3 pulse
//   BR_COUNT, MP_COUNT         : saturating statistics counters
module branch_resolve_unit
    import common_params::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EX_VALID,
    output logic             EX_READY,
    input  logic             IS_BRANCH,
    input  logic             IS_JAL,
    input  logic             IS_JALR,
    input  logic [2:0]       FUNCT3,
    input  logic             LT,
    input  logic             LTU,
    input  logic             EQ,
    input  logic             PRED_TAKEN,
    input  logic [BITS-1:0]  PC,
    input  logic [BITS-1:0]  TARGET,
    input  logic             REDIR_READY,
    output logic             REDIR_VALID,
    output logic [BITS-1:0]  REDIR_PC,
    output logic             FLUSH,
    output logic             TAKEN,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] BR_COUNT,
    output logic [CNT_W-1:0] MP_COUNT
);

    brs_state_t      r_state;
    brs_state_t      w_state_next;
    logic [3:0]      r_sq_cnt;
    logic [3:0]      w_sq_cnt_next;
    logic [BITS-1:0] r_redir_pc;
    logic            r_taken;
    logic            r_illegal;

    logic            w_ready;
    logic            w_accept;
    logic            w_br_taken;
    logic            w_f3_bad;
    logic            w_taken;
    logic            w_mispredict;
    logic            w_handshake;
    logic [BITS-1:0] w_target;
    logic [BITS-1:0] w_seq_pc;
    logic [BITS-1:0] w_correct_pc;

    assign w_ready  = (r_state == IDLE);
    assign w_accept = EX_VALID & w_ready & (IS_BRANCH | IS_JAL | IS_JALR);

    // Branch condition decode; the two unused encodings resolve not-taken.
    always_comb begin
        w_br_taken = 1'b0;
        w_f3_bad   = 1'b0;
        case (FUNCT3)
            F3_BEQ:  w_br_taken = EQ;
            F3_BNE:  w_br_taken = ~EQ;
            F3_BLT:  w_br_taken = LT;
            F3_BGE:  w_br_taken = ~LT;
            F3_BLTU: w_br_taken = LTU;
            F3_BGEU: w_br_taken = ~LTU;
            default: w_f3_bad   = 1'b1;
        endcase
    end

    assign w_taken      = (IS_JALR | IS_JAL) ? 1'b1 : w_br_taken;
    assign w_target     = IS_JALR ? {TARGET[BITS-1:1], 1'b0} : TARGET;
    assign w_seq_pc     = PC + BITS'(INSTR_BYTES);
    assign w_correct_pc = w_taken ? w_target : w_seq_pc;
    assign w_mispredict = (w_taken != PRED_TAKEN);
    assign w_handshake  = (r_state == REDIRECT) & REDIR_READY;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sq_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_sq_cnt <= w_sq_cnt_next;
        end
    end

    // The handshake cycle is the first of the FLUSH_CYCLES flush cycles, so
    // SQUASH only has to cover the remaining FLUSH_CYCLES-1; the counter is
    // loaded with the number of SQUASH cycles still to go after the first.
    always_comb begin
        w_state_next  = r_state;
        w_sq_cnt_next = r_sq_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && w_mispredict) begin
                    w_state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                if (w_handshake) begin
                    if (FLUSH_CYCLES > 1) begin
                        w_state_next  = SQUASH;
                        w_sq_cnt_next = 4'(FLUSH_CYCLES - 2);
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            SQUASH: begin
                if (r_sq_cnt == 4'd0) begin
                    w_state_next = IDLE;
                end else begin
                    w_sq_cnt_next = r_sq_cnt - 4'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redir_pc <= '0;
            r_taken    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            // Only a branch (not a jump that also has IS_BRANCH set) can be illegal.
            r_illegal <= w_accept & IS_BRANCH & ~IS_JAL & ~IS_JALR & w_f3_bad;
            if (w_accept) begin
                r_taken <= w_taken;
            end
            if (w_accept && w_mispredict) begin
                r_redir_pc <= w_correct_pc;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_br_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_accept),
        .count (BR_COUNT)
    );

    sat_counter #(.W(CNT_W)) u_mp_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_accept & w_mispredict),
        .count (MP_COUNT)
    );

    assign EX_READY    = w_ready;
    assign REDIR_VALID = (r_state == REDIRECT);
    assign FLUSH       = (r_state != IDLE);
    assign REDIR_PC    = r_redir_pc;
    assign TAKEN       = r_taken;
    assign ILLEGAL     = r_illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int BITS = 32;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            EX_VALID, EX_READY;
    logic            IS_BRANCH, IS_JAL, IS_JALR;
    logic [2:0]      FUNCT3;
    logic            LT, LTU, EQ, PRED_TAKEN;
    logic [BITS-1:0] PC, TARGET;
    logic            REDIR_READY, REDIR_VALID;
    logic [BITS-1:0] REDIR_PC;
    logic            FLUSH, TAKEN, ILLEGAL;
    logic [CW-1:0]   BR_COUNT, MP_COUNT;

    always #5 clk = ~clk;

    branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .EX_VALID(EX_VALID), .EX_READY(EX_READY),
        .IS_BRANCH(IS_BRANCH), .IS_JAL(IS_JAL), .IS_JALR(IS_JALR),
        .FUNCT3(FUNCT3), .LT(LT), .LTU(LTU), .EQ(EQ), .PRED_TAKEN(PRED_TAKEN),
        .PC(PC), .TARGET(TARGET), .REDIR_READY(REDIR_READY),
        .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .FLUSH(FLUSH),
        .TAKEN(TAKEN), .ILLEGAL(ILLEGAL), .BR_COUNT(BR_COUNT), .MP_COUNT(MP_COUNT)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a pending redirect flag plus a count of flush
    // cycles still owed after the handshake.
    bit          m_pending;
    int          m_flush_left;
    bit          m_taken, m_ill;
    logic [31:0] m_pc;
    int          m_br, m_mp;
    bit          m_tk;
    logic [31:0] m_dest;

    function automatic bit cond_taken(input logic [2:0] f3, input logic lt, input logic ltu, input logic eq);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pending = 0; m_flush_left = 0; m_taken = 0; m_ill = 0;
            m_pc = 0; m_br = 0; m_mp = 0;
        end else begin
            m_ill = 0;
            if (m_pending) begin
                if (REDIR_READY) begin
                    m_pending    = 0;
                    m_flush_left = FC - 1;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (EX_VALID && (IS_BRANCH || IS_JAL || IS_JALR)) begin
                if (IS_JALR) begin
                    m_tk = 1; m_dest = TARGET & ~32'h1;
                end else if (IS_JAL) begin
                    m_tk = 1; m_dest = TARGET;
                end else begin
                    m_tk = cond_taken(FUNCT3, LT, LTU, EQ); m_dest = TARGET;
                    m_ill = (FUNCT3 == 3'd2) || (FUNCT3 == 3'd3);
                end
                m_taken = m_tk;
                if (m_br < MAXC) m_br++;
                if (m_tk != PRED_TAKEN) begin
                    if (m_mp < MAXC) m_mp++;
                    m_pc      = m_tk ? m_dest : PC + 32'd4;
                    m_pending = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit busy;
        busy = m_pending || (m_flush_left > 0);
        check("EX_READY", 32'(EX_READY), 32'(!busy));
        check("REDIR_VALID", 32'(REDIR_VALID), 32'(m_pending));
        check("FLUSH", 32'(FLUSH), 32'(busy));
        check("REDIR_PC", REDIR_PC, m_pc);
        check("TAKEN", 32'(TAKEN), 32'(m_taken));
        check("ILLEGAL", 32'(ILLEGAL), 32'(m_ill));
        check("BR_COUNT", 32'(BR_COUNT), 32'(m_br));
        check("MP_COUNT", 32'(MP_COUNT), 32'(m_mp));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_in();
        EX_VALID = 0; IS_BRANCH = 0; IS_JAL = 0; IS_JALR = 0; FUNCT3 = 0;
        LT = 0; LTU = 0; EQ = 0; PRED_TAKEN = 0; PC = 0; TARGET = 0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (EX_READY !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (EX_READY !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: EX_READY=%b still not 1 after 20 cycles", EX_READY);
        end
    endtask

    initial begin
        clear_in();
        REDIR_READY = 0;
        rst = 1;
        tick();
        check("rst_EX_READY", 32'(EX_READY), 32'd1);
        check("rst_BR", 32'(BR_COUNT), 32'd0);
        check("rst_REDIR_PC", REDIR_PC, 32'd0);
        rst = 0;
        tick();

        // BEQ taken, predicted not taken
        EX_VALID = 1; IS_BRANCH = 1; FUNCT3 = 3'd0; EQ = 1; PRED_TAKEN = 0;
        PC = 32'h100; TARGET = 32'h180; REDIR_READY = 1;
        tick();
        check("beq_valid", 32'(REDIR_VALID), 32'd1);
        check("beq_pc", REDIR_PC, 32'h180);
        check("beq_taken", 32'(TAKEN), 32'd1);
        check("beq_mp", 32'(MP_COUNT), 32'd1);
        check("beq_ready", 32'(EX_READY), 32'd0);
        clear_in();
        tick();
        check("beq_flush2", 32'(FLUSH), 32'd1);
        check("beq_valid2", 32'(REDIR_VALID), 32'd0);
        tick();
        check("beq_flush3", 32'(FLUSH), 32'd0);

        // BLTU not taken, predicted taken, PC+4 wraps
        EX_VALID = 1; IS_BRANCH = 1; FUNCT3 = 3'd6; LTU = 0; PRED_TAKEN = 1;
        PC = 32'hFFFF_FFFC; TARGET = 32'h1234;
        tick();
        check("bltu_pc", REDIR_PC, 32'h0);
        check("bltu_taken", 32'(TAKEN), 32'd0);
        clear_in();
        wait_idle();

        // BGE correctly predicted
        rst = 1; tick(); rst = 0;
        EX_VALID = 1; IS_BRANCH = 1; FUNCT3 = 3'd5; LT = 0; PRED_TAKEN = 1;
        PC = 32'h300; TARGET = 32'h340;
        tick();
        check("bge_valid", 32'(REDIR_VALID), 32'd0);
        check("bge_flush", 32'(FLUSH), 32'd0);
        check("bge_br", 32'(BR_COUNT), 32'd1);
        check("bge_mp", 32'(MP_COUNT), 32'd0);
        clear_in();

        // JALR with stalled fetch, new EX_VALID ignored meanwhile
        EX_VALID = 1; IS_JALR = 1; TARGET = 32'h203; PC = 32'h400;
        PRED_TAKEN = 0; REDIR_READY = 0;
        tick();
        check("jalr_pc1", REDIR_PC, 32'h202);
        IS_JALR = 0; IS_JAL = 1; TARGET = 32'h999;
        for (int i = 2; i <= 4; i++) begin
            if (i > 2) tick();
            else tick();
            check("jalr_hold_valid", 32'(REDIR_VALID), 32'd1);
            check("jalr_hold_pc", REDIR_PC, 32'h202);
        end
        REDIR_READY = 1;
        tick();
        check("jalr_sq_flush", 32'(FLUSH), 32'd1);
        check("jalr_sq_valid", 32'(REDIR_VALID), 32'd0);
        clear_in();
        tick();
        check("jalr_done_flush", 32'(FLUSH), 32'd0);
        check("jalr_br", 32'(BR_COUNT), 32'd2);
        check("jalr_mp", 32'(MP_COUNT), 32'd1);

        // Illegal FUNCT3, predicted taken then not taken
        EX_VALID = 1; IS_BRANCH = 1; FUNCT3 = 3'd2; PRED_TAKEN = 1; PC = 32'h500;
        tick();
        check("ill_pulse", 32'(ILLEGAL), 32'd1);
        check("ill_taken", 32'(TAKEN), 32'd0);
        check("ill_pc", REDIR_PC, 32'h504);
        clear_in();
        tick();
        check("ill_end", 32'(ILLEGAL), 32'd0);
        wait_idle();
        EX_VALID = 1; IS_BRANCH = 1; FUNCT3 = 3'd3; PRED_TAKEN = 0; PC = 32'h600;
        tick();
        check("ill2_pulse", 32'(ILLEGAL), 32'd1);
        check("ill2_valid", 32'(REDIR_VALID), 32'd0);
        clear_in();
        tick();

        // Reset while in REDIRECT
        EX_VALID = 1; IS_JAL = 1; TARGET = 32'h800; PRED_TAKEN = 0; REDIR_READY = 0;
        tick();
        check("rr_valid", 32'(REDIR_VALID), 32'd1);
        clear_in();
        rst = 1;
        tick();
        check("rr_valid0", 32'(REDIR_VALID), 32'd0);
        check("rr_flush0", 32'(FLUSH), 32'd0);
        check("rr_pc0", REDIR_PC, 32'd0);
        check("rr_mp0", 32'(MP_COUNT), 32'd0);
        rst = 0;
        REDIR_READY = 1;

        // Counter saturation
        for (int i = 0; i < MAXC + 2; i++) begin
            EX_VALID = 1; IS_JAL = 1; TARGET = 32'(i * 16); PRED_TAKEN = 0;
            tick();
            clear_in();
            wait_idle();
        end
        check("sat_mp", 32'(MP_COUNT), 32'(MAXC));
        check("sat_br", 32'(BR_COUNT), 32'(MAXC));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            EX_VALID    = ($urandom_range(0, 9) < 6);
            IS_BRANCH   = $urandom_range(0, 1);
            IS_JAL      = ($urandom_range(0, 3) == 0);
            IS_JALR     = ($urandom_range(0, 3) == 0);
            FUNCT3      = 3'($urandom_range(0, 7));
            LT          = $urandom_range(0, 1);
            LTU         = $urandom_range(0, 1);
            EQ          = $urandom_range(0, 1);
            PRED_TAKEN  = $urandom_range(0, 1);
            PC          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            TARGET      = $urandom;
            REDIR_READY = $urandom_range(0, 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
